// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/return sequencing controller.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2,
    RET   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_TRAP = 2'd1,
    EVT_MRET = 2'd2
  } evt_e;

  localparam logic [3:0] IRQ_EXT   = 4'd11;
  localparam logic [3:0] IRQ_TIMER = 4'd7;

endpackage

// File: rtl/trap_prio_enc.sv
// Picks the single event the execute stage presents this cycle:
// exception > MRET > external interrupt > timer interrupt.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_exc_req,
  input  logic [3:0]  ex_exc_cause,
  input  logic [31:0] ex_exc_tval,
  input  logic        ex_is_mret,
  input  logic        timer_int,
  input  logic        ext_int,
  input  logic        mie,
  output logic [1:0]  evt_type,
  output logic        evt_is_irq,
  output logic [3:0]  evt_cause,
  output logic [31:0] evt_tval
);

  always_comb begin
    evt_type   = EVT_NONE;
    evt_is_irq = 1'b0;
    evt_cause  = '0;
    evt_tval   = '0;
    if (ex_valid) begin
      if (ex_exc_req) begin
        evt_type  = EVT_TRAP;
        evt_cause = ex_exc_cause;
        evt_tval  = ex_exc_tval;
      end else if (ex_is_mret) begin
        evt_type = EVT_MRET;
      end else if (mie && ext_int) begin
        evt_type   = EVT_TRAP;
        evt_is_irq = 1'b1;
        evt_cause  = IRQ_EXT;
      end else if (mie && timer_int) begin
        evt_type   = EVT_TRAP;
        evt_is_irq = 1'b1;
        evt_cause  = IRQ_TIMER;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: accepts one event from execute, drains the pipe,
// then issues a single commit pulse and fetch redirect.
//
// state | meaning
// IDLE  | waiting for a valid instruction carrying an event
// DRAIN | flushing, waiting for pipe_busy to clear or the drain timeout
// TRAP  | one cycle: commit trap state to CSRs, redirect to mtvec
// RET   | one cycle: commit MRET, redirect to mepc
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_exc_req,
  input  logic [3:0]  ex_exc_cause,
  input  logic [31:0] ex_exc_tval,
  input  logic        ex_is_mret,
  input  logic        timer_int,
  input  logic        ext_int,
  input  logic        mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        pipe_busy,
  output logic        flush,
  output logic        exc_taken,
  output logic        exc_is_irq,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_tval,
  output logic [31:0] exc_pc,
  output logic        mret_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_err
);

  state_e      state_q, state_d;
  evt_e        type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [3:0]  cause_q, cause_d;
  logic        irq_q, irq_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drain_err_q, drain_err_d;

  logic [1:0]  evt_type_raw;
  evt_e        evt_type;
  logic        evt_is_irq;
  logic [3:0]  evt_cause;
  logic [31:0] evt_tval;
  logic        cnt_done;

  trap_prio_enc u_prio (
    .ex_valid     (ex_valid),
    .ex_exc_req   (ex_exc_req),
    .ex_exc_cause (ex_exc_cause),
    .ex_exc_tval  (ex_exc_tval),
    .ex_is_mret   (ex_is_mret),
    .timer_int    (timer_int),
    .ext_int      (ext_int),
    .mie          (mie),
    .evt_type     (evt_type_raw),
    .evt_is_irq   (evt_is_irq),
    .evt_cause    (evt_cause),
    .evt_tval     (evt_tval)
  );

  assign evt_type = evt_e'(evt_type_raw);

  // The exit decision uses the post-increment count, so DRAIN lasts at most DRAIN_MAX cycles.
  assign cnt_done = (int'(cnt_q) + 1) >= DRAIN_MAX;

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    pc_d           = pc_q;
    tval_d         = tval_q;
    cause_d        = cause_q;
    irq_d          = irq_q;
    cnt_d          = cnt_q;
    drain_err_d    = drain_err_q;
    flush          = 1'b0;
    exc_taken      = 1'b0;
    mret_taken     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (evt_type != EVT_NONE) begin
          flush   = 1'b1;
          type_d  = evt_type;
          pc_d    = ex_pc;
          cause_d = evt_cause;
          tval_d  = evt_tval;
          irq_d   = evt_is_irq;
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        flush = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (!pipe_busy || cnt_done) begin
          if (pipe_busy) drain_err_d = 1'b1;
          state_d = (type_q == EVT_MRET) ? RET : TRAP;
        end
      end
      TRAP: begin
        flush          = 1'b1;
        exc_taken      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {mtvec[31:2], 2'b00};
        state_d        = IDLE;
      end
      RET: begin
        flush          = 1'b1;
        mret_taken     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      type_q      <= EVT_NONE;
      pc_q        <= '0;
      tval_q      <= '0;
      cause_q     <= '0;
      irq_q       <= 1'b0;
      cnt_q       <= '0;
      drain_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      pc_q        <= pc_d;
      tval_q      <= tval_d;
      cause_q     <= cause_d;
      irq_q       <= irq_d;
      cnt_q       <= cnt_d;
      drain_err_q <= drain_err_d;
    end
  end

  assign exc_is_irq = irq_q;
  assign exc_cause  = cause_q;
  assign exc_tval   = tval_q;
  assign exc_pc     = pc_q;
  assign drain_err  = drain_err_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: stimulus queues the expected commit pulse,
// a negedge monitor pops and checks it whenever exc_taken or mret_taken fires.
module tb_trap_ctrl;

  localparam int DRAIN_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_exc_req, ex_is_mret, timer_int, ext_int, mie, pipe_busy;
  logic [31:0] ex_pc, ex_exc_tval, mtvec, mepc;
  logic [3:0]  ex_exc_cause;
  logic        flush, exc_taken, exc_is_irq, mret_taken, redirect_valid, drain_err;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval, exc_pc, redirect_pc;

  trap_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_exc_req     (ex_exc_req),
    .ex_exc_cause   (ex_exc_cause),
    .ex_exc_tval    (ex_exc_tval),
    .ex_is_mret     (ex_is_mret),
    .timer_int      (timer_int),
    .ext_int        (ext_int),
    .mie            (mie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .pipe_busy      (pipe_busy),
    .flush          (flush),
    .exc_taken      (exc_taken),
    .exc_is_irq     (exc_is_irq),
    .exc_cause      (exc_cause),
    .exc_tval       (exc_tval),
    .exc_pc         (exc_pc),
    .mret_taken     (mret_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .drain_err      (drain_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_mret;
    bit          is_irq;
    logic [3:0]  cause;
    logic [31:0] tval;
    logic [31:0] pc;
    logic [31:0] rpc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_trap(input bit irq, input logic [3:0] cause, input logic [31:0] tval,
                           input logic [31:0] pc, input logic [31:0] rpc, input int at);
    exp_t e;
    e.is_mret = 1'b0; e.is_irq = irq; e.cause = cause; e.tval = tval;
    e.pc = pc; e.rpc = rpc; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic push_mret(input logic [31:0] rpc, input int at);
    exp_t e;
    e.is_mret = 1'b1; e.is_irq = 1'b0; e.cause = '0; e.tval = '0;
    e.pc = '0; e.rpc = rpc; e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: every commit pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (exc_taken || mret_taken) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: exc_taken=%0b mret_taken=%0b at cycle %0d, expected none",
                 exc_taken, mret_taken, cyc);
      end else begin
        m_e = sb.pop_front();
        chk("pulse_cycle", cyc, m_e.cyc);
        chk("pulse_flush", {31'd0, flush}, 32'd1);
        chk("pulse_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("pulse_redirect_pc", redirect_pc, m_e.rpc);
        if (m_e.is_mret) begin
          chk("mret_taken", {31'd0, mret_taken}, 32'd1);
          chk("mret_no_exc_taken", {31'd0, exc_taken}, 32'd0);
        end else begin
          chk("exc_taken", {31'd0, exc_taken}, 32'd1);
          chk("exc_no_mret_taken", {31'd0, mret_taken}, 32'd0);
          chk("exc_is_irq", {31'd0, exc_is_irq}, {31'd0, m_e.is_irq});
          chk("exc_cause", {28'd0, exc_cause}, {28'd0, m_e.cause});
          chk("exc_tval", exc_tval, m_e.tval);
          chk("exc_pc", exc_pc, m_e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_exc_req = 1'b0; ex_is_mret = 1'b0;
    timer_int = 1'b0; ext_int = 1'b0;
    ex_exc_cause = '0; ex_exc_tval = '0; ex_pc = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_exc(input logic [3:0] cause, input logic [31:0] tval, input logic [31:0] pc);
    ex_valid = 1'b1; ex_exc_req = 1'b1; ex_exc_cause = cause; ex_exc_tval = tval; ex_pc = pc;
  endtask

  int n;

  initial begin
    idle_inputs();
    mie = 1'b0; pipe_busy = 1'b0; mtvec = 32'h100; mepc = 32'h0;
    rst_n = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_exc_pc", exc_pc, 32'd0);
    chk("rst_drain_err", {31'd0, drain_err}, 32'd0);
    rst_n = 1'b1;

    // Illegal instruction, minimum latency.
    next_cycle();
    raise_exc(4'd2, 32'hDEAD, 32'h200);
    n = cyc;
    push_trap(1'b0, 4'd2, 32'hDEAD, 32'h200, 32'h100, n + 2);
    @(negedge clk); chk("t1_flush_accept", {31'd0, flush}, 32'd1);
    next_cycle(); idle_inputs();
    @(negedge clk); chk("t1_flush_drain", {31'd0, flush}, 32'd1);
    next_cycle();
    @(negedge clk); chk("t1_flush_trap", {31'd0, flush}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t1_flush_idle", {31'd0, flush}, 32'd0);
    chk("t1_redirect_idle", {31'd0, redirect_valid}, 32'd0);
    chk("t1_exc_pc_hold", exc_pc, 32'h200);
    chk("t1_exc_cause_hold", {28'd0, exc_cause}, 32'd2);

    // MRET with a pending enabled timer interrupt in the same cycle: MRET wins.
    next_cycle();
    mepc = 32'h340; mie = 1'b1;
    ex_valid = 1'b1; ex_is_mret = 1'b1; timer_int = 1'b1; ex_pc = 32'h344;
    n = cyc;
    push_mret(32'h340, n + 2);
    next_cycle(); idle_inputs();
    repeat (2) next_cycle();

    // Both interrupts enabled: external wins, tval forced to 0, mtvec low bits cleared.
    next_cycle();
    mtvec = 32'h103;
    ex_valid = 1'b1; ext_int = 1'b1; timer_int = 1'b1; ex_exc_tval = 32'hFFFF; ex_pc = 32'h400;
    n = cyc;
    push_trap(1'b1, 4'd11, 32'h0, 32'h400, 32'h100, n + 2);
    next_cycle(); idle_inputs();
    repeat (2) next_cycle();

    // Timer alone.
    next_cycle();
    ex_valid = 1'b1; timer_int = 1'b1; ex_pc = 32'h900;
    n = cyc;
    push_trap(1'b1, 4'd7, 32'h0, 32'h900, 32'h100, n + 2);
    next_cycle(); idle_inputs();
    repeat (2) next_cycle();

    // Exception outranks MRET and interrupts.
    next_cycle();
    raise_exc(4'd4, 32'h44, 32'hA00); ex_is_mret = 1'b1; ext_int = 1'b1;
    n = cyc;
    push_trap(1'b0, 4'd4, 32'h44, 32'hA00, 32'h100, n + 2);
    next_cycle(); idle_inputs();
    repeat (2) next_cycle();

    // mie=0 masks interrupts; ex_valid=0 masks everything.
    next_cycle();
    mie = 1'b0; ex_valid = 1'b1; ext_int = 1'b1; timer_int = 1'b1;
    @(negedge clk); chk("t4_no_accept_mie0", {31'd0, flush}, 32'd0);
    next_cycle();
    ex_valid = 1'b0; ex_exc_req = 1'b1; ex_is_mret = 1'b1; mie = 1'b1;
    @(negedge clk); chk("t4_no_accept_invalid", {31'd0, flush}, 32'd0);
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk); chk("t4_still_idle", {31'd0, flush}, 32'd0);

    // pipe_busy high for 5 cycles; interrupt drops right after acceptance.
    next_cycle();
    pipe_busy = 1'b1; ex_valid = 1'b1; ext_int = 1'b1; ex_pc = 32'h500;
    n = cyc;
    push_trap(1'b1, 4'd11, 32'h0, 32'h500, 32'h100, n + 6);
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();
    next_cycle(); pipe_busy = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk); chk("t5_no_drain_err", {31'd0, drain_err}, 32'd0);

    // pipe_busy stuck: forced progress after DRAIN_MAX cycles, sticky drain_err.
    next_cycle();
    pipe_busy = 1'b1;
    raise_exc(4'd5, 32'h1234, 32'h600);
    n = cyc;
    push_trap(1'b0, 4'd5, 32'h1234, 32'h600, 32'h100, n + 1 + DRAIN_MAX);
    next_cycle(); idle_inputs();
    repeat (8) next_cycle();
    @(negedge clk);
    chk("t6_drain_err_early", {31'd0, drain_err}, 32'd0);
    chk("t6_flush_draining", {31'd0, flush}, 32'd1);
    repeat (8) next_cycle();
    pipe_busy = 1'b0;
    @(negedge clk);
    chk("t6_drain_err_set", {31'd0, drain_err}, 32'd1);
    chk("t6_idle_after", {31'd0, flush}, 32'd0);

    // Reset during DRAIN abandons the event.
    next_cycle();
    pipe_busy = 1'b1;
    raise_exc(4'd1, 32'h77, 32'h700);
    next_cycle(); idle_inputs();
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_flush", {31'd0, flush}, 32'd0);
    chk("t7_rst_exc_pc", exc_pc, 32'd0);
    chk("t7_rst_exc_cause", {28'd0, exc_cause}, 32'd0);
    chk("t7_rst_drain_err", {31'd0, drain_err}, 32'd0);
    chk("t7_rst_redirect", {31'd0, redirect_valid}, 32'd0);
    next_cycle();
    rst_n = 1'b1; pipe_busy = 1'b0;
    repeat (20) next_cycle();
    @(negedge clk); chk("t7_idle_after_rst", {31'd0, flush}, 32'd0);

    // Fresh exception after reset completes normally.
    next_cycle();
    raise_exc(4'd3, 32'hBEEF, 32'h800);
    n = cyc;
    push_trap(1'b0, 4'd3, 32'hBEEF, 32'h800, 32'h100, n + 2);
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();

    for (int i = 0; i < 50 && sb.size() != 0; i++) next_cycle();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
